// File: rtl/sd_sched_if.sv
// Bundle of requester, status and SD-controller signals around sd_sched.
// master = the scheduler itself, slave = requesters plus SD controller.
interface sd_sched_if;
    logic [1:0]  rq_req;
    logic        rq_rw0;
    logic [31:0] rq_lba0;
    logic [7:0]  rq_cnt0;
    logic        rq_rw1;
    logic [31:0] rq_lba1;
    logic [7:0]  rq_cnt1;
    logic [1:0]  rq_grant;
    logic [1:0]  rq_done;
    logic [3:0]  rq_err;
    logic        sec_strobe;
    logic [7:0]  sec_idx;
    logic        sd_command;
    logic        sd_rw;
    logic [31:0] sd_lba;
    logic [1:0]  sd_card;
    logic [3:0]  sd_error;
    logic        sd_done;
    logic        sd_busy;

    modport master (
        input  rq_req, rq_rw0, rq_lba0, rq_cnt0, rq_rw1, rq_lba1, rq_cnt1,
        input  sd_card, sd_error, sd_done, sd_busy,
        output rq_grant, rq_done, rq_err, sec_strobe, sec_idx,
        output sd_command, sd_rw, sd_lba
    );

    modport slave (
        output rq_req, rq_rw0, rq_lba0, rq_cnt0, rq_rw1, rq_lba1, rq_cnt1,
        output sd_card, sd_error, sd_done, sd_busy,
        input  rq_grant, rq_done, rq_err, sec_strobe, sec_idx,
        input  sd_command, sd_rw, sd_lba
    );
endinterface

// File: rtl/sd_sched.sv
// Round-robin job sequencer for the shared SD controller: grants one multi-sector
// job at a time and issues one sd_command per sector on consecutive LBAs.
module sd_sched #(
    parameter logic [23:0] TIMEOUT = 24'd12500000
) (
    input  logic     i_clock,
    input  logic     i_reset,
    sd_sched_if.master bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]  r_state;
    logic        r_rr;
    logic        r_sel;
    logic [1:0]  r_grant;
    logic [1:0]  r_done;
    logic [3:0]  r_err;
    logic [3:0]  r_job_err;
    logic        r_strobe;
    logic [7:0]  r_sec_idx;
    logic        r_cmd;
    logic        r_sd_rw;
    logic [31:0] r_sd_lba;
    logic        r_cur_rw;
    logic [31:0] r_cur_lba;
    logic [7:0]  r_remain;
    logic [7:0]  r_idx;
    logic [23:0] r_tmo;

    logic        w_sel;
    logic [1:0]  w_sel_onehot;
    logic        w_rw;
    logic [31:0] w_lba;
    logic [7:0]  w_cnt;

    // With both requesters pending the rr pointer decides; otherwise the lone one wins.
    assign w_sel = (bus.rq_req == 2'b11) ? r_rr : bus.rq_req[1];
    assign w_rw  = w_sel ? bus.rq_rw1  : bus.rq_rw0;
    assign w_lba = w_sel ? bus.rq_lba1 : bus.rq_lba0;
    assign w_cnt = w_sel ? bus.rq_cnt1 : bus.rq_cnt0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
            assign w_sel_onehot[gi] = (w_sel == gi[0]);
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_rr      <= 1'b0;
            r_sel     <= 1'b0;
            r_grant   <= 2'b00;
            r_done    <= 2'b00;
            r_err     <= 4'h0;
            r_job_err <= 4'h0;
            r_strobe  <= 1'b0;
            r_sec_idx <= 8'd0;
            r_cmd     <= 1'b0;
            r_sd_rw   <= 1'b0;
            r_sd_lba  <= 32'd0;
            r_cur_rw  <= 1'b0;
            r_cur_lba <= 32'd0;
            r_remain  <= 8'd0;
            r_idx     <= 8'd0;
            r_tmo     <= 24'd0;
        end else begin
            r_cmd    <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (bus.rq_req != 2'b00 && !bus.sd_busy) begin
                        r_sel     <= w_sel;
                        r_grant   <= w_sel_onehot;
                        r_cur_rw  <= w_rw;
                        r_cur_lba <= w_lba;
                        r_remain  <= w_cnt;
                        r_idx     <= 8'd0;
                        if (bus.sd_card == 2'b00) begin
                            r_job_err <= 4'hE;
                            r_state   <= S_FINISH;
                        end else if (w_cnt == 8'd0) begin
                            r_job_err <= 4'h0;
                            r_state   <= S_FINISH;
                        end else begin
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!bus.sd_busy) begin
                        r_sd_lba <= r_cur_lba;
                        r_sd_rw  <= r_cur_rw;
                        r_cmd    <= 1'b1;
                        r_tmo    <= 24'd0;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // sd_done is tested first so it beats a coincident timeout.
                    if (bus.sd_done) begin
                        if (bus.sd_error != 4'h0) begin
                            r_job_err <= bus.sd_error;
                            r_state   <= S_FINISH;
                        end else begin
                            r_strobe  <= 1'b1;
                            r_sec_idx <= r_idx;
                            r_idx     <= r_idx + 8'd1;
                            r_cur_lba <= r_cur_lba + 32'd1;
                            r_remain  <= r_remain - 8'd1;
                            if (r_remain == 8'd1) begin
                                r_job_err <= 4'h0;
                                r_state   <= S_FINISH;
                            end else begin
                                r_state   <= S_ISSUE;
                            end
                        end
                    end else if (r_tmo + 24'd1 == TIMEOUT) begin
                        r_job_err <= 4'hF;
                        r_state   <= S_FINISH;
                    end else begin
                        r_tmo <= r_tmo + 24'd1;
                    end
                end
                S_FINISH: begin
                    r_done  <= r_grant;
                    r_err   <= r_job_err;
                    r_grant <= 2'b00;
                    r_rr    <= ~r_sel;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rq_grant   = r_grant;
    assign bus.rq_done    = r_done;
    assign bus.rq_err     = r_err;
    assign bus.sec_strobe = r_strobe;
    assign bus.sec_idx    = r_sec_idx;
    assign bus.sd_command = r_cmd;
    assign bus.sd_rw      = r_sd_rw;
    assign bus.sd_lba     = r_sd_lba;
endmodule

// File: tb/tb_sd_sched.sv
// Bench for sd_sched: directed scenarios plus randomized jobs, scored against a
// job-level model (expected commands, sectors, result code, rr order).
module tb_sd_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sd_sched_if bus();

    sd_sched #(.TIMEOUT(24'd100)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        int          req;
        logic        rw;
        logic [31:0] lba;
        int          ncmd;
        int          nstr;
        logic [3:0]  err;
    } job_t;

    int checks = 0;
    int errors = 0;
    job_t job_q[$];

    // Per-requester job parameters and SD-controller behaviour.
    logic        p_rw[2];
    logic [31:0] p_lba[2];
    logic [7:0]  p_cnt[2];
    int          err_sec[2];
    logic [3:0]  err_code[2];
    bit          hang[2];
    logic [1:0]  card;
    int          cfg_delay;
    int          rr_model;

    // Monitor bookkeeping.
    int          cyc = 0;
    int          cmd_seen = 0;
    int          str_seen = 0;
    int          cmds_total = 0;
    int          last_cmd_cyc = 0;
    int          last_done_cyc = 0;
    logic [31:0] last_lba = 32'd0;
    logic [3:0]  last_err = 4'h0;
    logic [3:0]  held_err = 4'h0;
    int          grant_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job outcome derived from the job parameters and the SD behaviour for that requester.
    function automatic job_t model(input int r);
        job_t j;
        j.req = r;
        j.rw  = p_rw[r];
        j.lba = p_lba[r];
        if (card == 2'b00) begin
            j.ncmd = 0; j.nstr = 0; j.err = 4'hE;
        end else if (p_cnt[r] == 8'd0) begin
            j.ncmd = 0; j.nstr = 0; j.err = 4'h0;
        end else if (hang[r]) begin
            j.ncmd = 1; j.nstr = 0; j.err = 4'hF;
        end else if (err_sec[r] < int'(p_cnt[r])) begin
            j.ncmd = err_sec[r] + 1; j.nstr = err_sec[r]; j.err = err_code[r];
        end else begin
            j.ncmd = int'(p_cnt[r]); j.nstr = int'(p_cnt[r]); j.err = 4'h0;
        end
        return j;
    endfunction

    // SD controller model: busy from command to done, done after a delay, optional error or hang.
    initial begin
        int cnt;
        int cmd_k;
        int r;
        logic [3:0] pend;
        cnt = 0; cmd_k = 0; pend = 4'h0;
        bus.sd_done = 1'b0; bus.sd_busy = 1'b0; bus.sd_error = 4'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.sd_done  = 1'b0;
            bus.sd_error = 4'h0;
            if (rst) begin
                cnt = 0; cmd_k = 0;
                bus.sd_busy = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.sd_done  = 1'b1;
                        bus.sd_busy  = 1'b0;
                        bus.sd_error = pend;
                    end
                end
                if (bus.rq_done != 2'b00) cmd_k = 0;
                if (bus.sd_command) begin
                    r = bus.rq_grant[1] ? 1 : 0;
                    if (!hang[r]) begin
                        bus.sd_busy = 1'b1;
                        cnt  = (cfg_delay != 0) ? cfg_delay : int'($urandom_range(1, 6));
                        pend = (cmd_k == err_sec[r]) ? err_code[r] : 4'h0;
                    end
                    cmd_k++;
                end
            end
        end
    end

    // Per-cycle compare process against the head of the expected-job queue.
    initial begin
        job_t cur;
        logic [1:0] exp_g;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                job_q.delete();
                cmd_seen = 0;
                str_seen = 0;
                held_err = 4'h0;
            end else if (job_q.size() == 0) begin
                if (bus.rq_grant != 2'b00 || bus.rq_done != 2'b00 || bus.sd_command || bus.sec_strobe)
                    chk("no_job_activity", {26'd0, bus.rq_grant, bus.rq_done, bus.sd_command, bus.sec_strobe}, 32'd0);
                chk("err_hold", bus.rq_err, held_err);
            end else begin
                cur   = job_q[0];
                exp_g = (cur.req == 1) ? 2'b10 : 2'b01;
                chk("grant_onehot", bus.rq_grant & ~exp_g, 32'd0);
                if (bus.sd_command) begin
                    chk("cmd_extra", (cmd_seen < cur.ncmd), 32'd1);
                    chk("cmd_lba", bus.sd_lba, cur.lba + 32'(cmd_seen));
                    chk("cmd_rw", bus.sd_rw, cur.rw);
                    chk("cmd_grant", bus.rq_grant, exp_g);
                    cmd_seen++;
                    cmds_total++;
                    last_cmd_cyc = cyc;
                    last_lba = bus.sd_lba;
                end
                if (bus.sec_strobe) begin
                    chk("sec_idx", bus.sec_idx, str_seen);
                    str_seen++;
                end
                if (bus.rq_done != 2'b00) begin
                    chk("done_vec", bus.rq_done, exp_g);
                    chk("done_grant_low", bus.rq_grant, 32'd0);
                    chk("done_err", bus.rq_err, cur.err);
                    chk("done_ncmd", cmd_seen, cur.ncmd);
                    chk("done_nstr", str_seen, cur.nstr);
                    $display("job req=%0d lba=%h rw=%0d cmds=%0d sectors=%0d err=%h",
                             cur.req, cur.lba, cur.rw, cmd_seen, str_seen, bus.rq_err);
                    held_err = cur.err;
                    last_err = bus.rq_err;
                    last_done_cyc = cyc;
                    grant_log.push_back(cur.req);
                    void'(job_q.pop_front());
                    cmd_seen = 0;
                    str_seen = 0;
                end else begin
                    chk("err_hold", bus.rq_err, held_err);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rq_req = 2'b00;
        @(negedge clk);
        chk("rst_grant", bus.rq_grant, 32'd0);
        chk("rst_done", bus.rq_done, 32'd0);
        chk("rst_err", bus.rq_err, 32'd0);
        chk("rst_cmd", bus.sd_command, 32'd0);
        chk("rst_rw", bus.sd_rw, 32'd0);
        chk("rst_lba", bus.sd_lba, 32'd0);
        chk("rst_strobe", bus.sec_strobe, 32'd0);
        chk("rst_idx", bus.sec_idx, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rr_model = 0;
    endtask

    task automatic set_req(input int r, input logic rw, input logic [31:0] lba, input logic [7:0] cnt,
                           input int esec, input logic [3:0] ecode, input bit hg);
        p_rw[r] = rw; p_lba[r] = lba; p_cnt[r] = cnt;
        err_sec[r] = esec; err_code[r] = ecode; hang[r] = hg;
    endtask

    task automatic drive_params();
        bus.rq_rw0 = p_rw[0]; bus.rq_lba0 = p_lba[0]; bus.rq_cnt0 = p_cnt[0];
        bus.rq_rw1 = p_rw[1]; bus.rq_lba1 = p_lba[1]; bus.rq_cnt1 = p_cnt[1];
        bus.sd_card = card;
    endtask

    // Post one or two jobs and wait for each to finish in the expected round-robin order.
    task automatic launch(input logic [1:0] reqs);
        int order[$];
        int waitc;
        if (reqs == 2'b11) begin
            order.push_back(rr_model);
            order.push_back(1 - rr_model);
        end else begin
            order.push_back(reqs[1] ? 1 : 0);
        end
        for (int k = 0; k < order.size(); k++) begin
            job_q.push_back(model(order[k]));
            rr_model = 1 - order[k];
        end
        @(negedge clk);
        drive_params();
        bus.rq_req = reqs;
        for (int k = 0; k < order.size(); k++) begin
            waitc = 0;
            while (bus.rq_done == 2'b00 && waitc < 3000) begin
                @(negedge clk);
                waitc++;
            end
            chk("job_completes", (waitc < 3000), 32'd1);
            if (waitc >= 3000) begin
                do_reset();
                return;
            end
            bus.rq_req[order[k]] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int waitc;
        int base;
        bus.rq_req = 2'b00;
        card = 2'b01;
        cfg_delay = 0;
        rr_model = 0;
        for (int r = 0; r < 2; r++) set_req(r, 1'b0, 32'd0, 8'd0, 255, 4'h0, 1'b0);
        drive_params();

        do_reset();

        // Three-sector read, 20-cycle SD latency.
        cfg_delay = 20;
        set_req(0, 1'b0, 32'd100, 8'd3, 255, 4'h0, 1'b0);
        launch(2'b01);
        chk("t1_last_lba", last_lba, 32'd102);
        chk("t1_err", last_err, 32'h0);
        cfg_delay = 0;

        // Simultaneous requests twice from fresh reset: grants alternate 0,1,0,1.
        do_reset();
        base = grant_log.size();
        set_req(0, 1'b1, 32'h1000, 8'd2, 255, 4'h0, 1'b0);
        set_req(1, 1'b0, 32'h2000, 8'd1, 255, 4'h0, 1'b0);
        launch(2'b11);
        launch(2'b11);
        chk("t2_order0", grant_log[base], 32'd0);
        chk("t2_order1", grant_log[base + 1], 32'd1);
        chk("t2_order2", grant_log[base + 2], 32'd0);
        chk("t2_order3", grant_log[base + 3], 32'd1);

        // SD error on the second of four sectors.
        set_req(1, 1'b1, 32'h300, 8'd4, 1, 4'h3, 1'b0);
        launch(2'b10);
        chk("t3_err", last_err, 32'h3);
        chk("t3_last_lba", last_lba, 32'h301);

        // SD never answers: timeout.
        set_req(0, 1'b0, 32'h40, 8'd2, 255, 4'h0, 1'b1);
        launch(2'b01);
        chk("t4_err", last_err, 32'hF);
        lat = last_done_cyc - last_cmd_cyc;
        chk("t4_latency_window", (lat >= 99 && lat <= 104), 32'd1);
        hang[0] = 1'b0;

        // No card, zero count, LBA wrap.
        card = 2'b00;
        set_req(0, 1'b0, 32'h55, 8'd3, 255, 4'h0, 1'b0);
        launch(2'b01);
        chk("t5_nocard_err", last_err, 32'hE);
        card = 2'b10;
        set_req(1, 1'b1, 32'h66, 8'd0, 255, 4'h0, 1'b0);
        launch(2'b10);
        chk("t5_zero_cnt_err", last_err, 32'h0);
        set_req(0, 1'b1, 32'hFFFF_FFFF, 8'd2, 255, 4'h0, 1'b0);
        launch(2'b01);
        chk("t5_wrap_lba", last_lba, 32'h0);

        // Reset while waiting on the SD controller, then a normal job.
        cfg_delay = 50;
        set_req(0, 1'b0, 32'd500, 8'd3, 255, 4'h0, 1'b0);
        job_q.push_back(model(0));
        base = cmds_total;
        @(negedge clk);
        drive_params();
        bus.rq_req = 2'b01;
        waitc = 0;
        while (cmds_total == base && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        chk("t6_cmd_issued", (cmds_total != base), 32'd1);
        repeat (3) @(negedge clk);
        do_reset();
        cfg_delay = 0;
        set_req(0, 1'b0, 32'd700, 8'd2, 255, 4'h0, 1'b0);
        launch(2'b01);
        chk("t6_after_reset_lba", last_lba, 32'd701);

        // Randomized jobs.
        for (int n = 0; n < 40; n++) begin
            card = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                set_req(r, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : 32'($urandom),
                        8'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
                        4'($urandom_range(1, 14)), ($urandom_range(0, 14) == 0));
            end
            launch(2'($urandom_range(1, 3)));
        end

        repeat (5) @(negedge clk);
        chk("final_queue_empty", job_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
